frequency_generator: RTL

//   Transmit-side counterpart of the frequency-measurement chain: accepts a 12-bit frequency code
//   and synthesises a square wave of that frequency on OUT. The code is converted to a period in
//   CLK cycles by an iterative divider, then split into high/low phase counts. OUT looped back into
//   the frequency-measurement path must read back the same code; that is the board self-test source.

---
 rtl/freq_pkg.sv | 13 +
 rtl/frequency_generator_seq_divider.sv | 60 ++++++
 rtl/frequency_generator.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/freq_pkg.sv
// Shared definitions for the square-wave frequency generator and its divider.
package freq_pkg;

  localparam int CNT_W_DEF  = 28;
  localparam int MIN_PERIOD = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    RUN    = 2'd2
  } state_e;

endpackage

// File: rtl/frequency_generator_seq_divider.sv
// Restoring divider: one quotient bit per cycle, CNT_W cycles after start.
module seq_divider #(
  parameter int CNT_W = 28
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] dividend_i,
  input  logic [CNT_W-1:0] divisor_i,
  output logic             done_o,
  output logic [CNT_W-1:0] quotient_o
);

  localparam int IW = $clog2(CNT_W + 1);

  logic             busy_q;
  logic [IW-1:0]    iter_q;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] quo_q, quo_d;
  logic [CNT_W-1:0] dvs_q;
  logic [CNT_W:0]   shifted, diff;

  // The remainder stays below the divisor, so a borrow in bit CNT_W means "does not fit".
  always_comb begin
    shifted = {rem_q, quo_q[CNT_W-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (diff[CNT_W]) begin
      rem_d = shifted[CNT_W-1:0];
      quo_d = {quo_q[CNT_W-2:0], 1'b0};
    end else begin
      rem_d = diff[CNT_W-1:0];
      quo_d = {quo_q[CNT_W-2:0], 1'b1};
    end
  end

  assign done_o     = busy_q && (iter_q == IW'(CNT_W - 1));
  assign quotient_o = quo_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      iter_q <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      iter_q <= '0;
      rem_q  <= '0;
      quo_q  <= dividend_i;
      dvs_q  <= divisor_i;
    end else if (busy_q) begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      iter_q <= iter_q + IW'(1);
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/frequency_generator.sv
// Square-wave synthesiser: frequency code -> period via sequential divide -> high/low phases.
module frequency_generator
  import freq_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int FREQ_UNIT_HZ = 1,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [11:0]      bnum,
  input  logic             load,
  output logic             ready,
  output logic             OUT,
  output logic             active,
  output logic [CNT_W-1:0] period
);

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIVIDEND = CNT_W'(CLK_HZ);

  function automatic logic [CNT_W-1:0] clamp_period(input logic [CNT_W-1:0] q);
    return (q < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : q;
  endfunction

  state_e           state_q, state_d;
  logic             accept, start_div, stop;
  logic             div_done;
  logic [CNT_W-1:0] divisor, quotient, new_per, new_on, new_off;

  logic             out_q, out_d, active_q, active_d, pend_q, pend_d;
  logic [CNT_W-1:0] period_q, period_d, phase_q, phase_d;
  logic [CNT_W-1:0] on_q, on_d, off_q, off_d;
  logic [CNT_W-1:0] pon_q, pon_d, poff_q, poff_d, pper_q, pper_d;

  assign divisor = CNT_W'(bnum) * CNT_W'(FREQ_UNIT_HZ);
  assign new_per = clamp_period(quotient);
  assign new_on  = new_per - (new_per >> 1);
  assign new_off = new_per >> 1;

  seq_divider #(.CNT_W(CNT_W)) u_div (
    .clk_i      (CLK),
    .rst_i      (RST),
    .start_i    (start_div),
    .dividend_i (DIVIDEND),
    .divisor_i  (divisor),
    .done_o     (div_done),
    .quotient_o (quotient)
  );

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_div) state_d = DIVIDE;
      DIVIDE:  if (div_done) state_d = RUN;
      RUN: begin
        if (stop)           state_d = IDLE;
        else if (start_div) state_d = DIVIDE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready     = (state_q != DIVIDE);
    accept    = load && ready;
    start_div = accept && (bnum != 12'd0);
    stop      = accept && (bnum == 12'd0);
  end

  // A retune result waits in the shadow registers until the next high-phase start.
  always_comb begin
    out_d    = out_q;
    active_d = active_q;
    period_d = period_q;
    phase_d  = phase_q;
    on_d     = on_q;
    off_d    = off_q;
    pend_d   = pend_q;
    pon_d    = pon_q;
    poff_d   = poff_q;
    pper_d   = pper_q;
    if (stop) begin
      out_d    = 1'b0;
      active_d = 1'b0;
      period_d = '0;
      phase_d  = '0;
      pend_d   = 1'b0;
    end else if (div_done && !active_q) begin
      out_d    = 1'b1;
      active_d = 1'b1;
      period_d = new_per;
      on_d     = new_on;
      off_d    = new_off;
      phase_d  = new_on - ONE;
    end else if (active_q) begin
      if (div_done) begin
        pend_d = 1'b1;
        pon_d  = new_on;
        poff_d = new_off;
        pper_d = new_per;
      end
      if (phase_q != '0) begin
        phase_d = phase_q - ONE;
      end else if (out_q) begin
        out_d   = 1'b0;
        phase_d = off_q - ONE;
      end else begin
        out_d = 1'b1;
        if (pend_d) begin
          period_d = pper_d;
          on_d     = pon_d;
          off_d    = poff_d;
          phase_d  = pon_d - ONE;
          pend_d   = 1'b0;
        end else begin
          phase_d  = on_q - ONE;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_q    <= 1'b0;
      active_q <= 1'b0;
      period_q <= '0;
      phase_q  <= '0;
      on_q     <= '0;
      off_q    <= '0;
      pend_q   <= 1'b0;
      pon_q    <= '0;
      poff_q   <= '0;
      pper_q   <= '0;
    end else begin
      out_q    <= out_d;
      active_q <= active_d;
      period_q <= period_d;
      phase_q  <= phase_d;
      on_q     <= on_d;
      off_q    <= off_d;
      pend_q   <= pend_d;
      pon_q    <= pon_d;
      poff_q   <= poff_d;
      pper_q   <= pper_d;
    end
  end

  assign OUT    = out_q;
  assign active = active_q;
  assign period = period_q;

endmodule
